// File: rtl/pwm_capture_if.sv
// Bus-side signal bundle of the PWM input-capture peripheral.
// The master drives writes and addresses; the slave returns combinational read data.
interface pwm_capture_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (
    output we_i,
    output addr_i,
    output data_i,
    input  data_o
  );

  modport slave (
    input  we_i,
    input  addr_i,
    input  data_i,
    output data_o
  );
endinterface

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in_i in clk cycles.
// Optional macro PWM_CAPTURE_IRQ_EN enables CTRL.IE and the level interrupt irq_o.
module pwm_capture #(
  parameter int          CNT_W       = 32,
  parameter logic [31:0] TIMEOUT_DEF = 32'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  pwm_capture_if.slave bus,
  input  logic        pwm_in_i,
  output logic        irq_o
);

  localparam logic [7:0] ADDR_CTRL    = 8'h00;
  localparam logic [7:0] ADDR_STATUS  = 8'h04;
  localparam logic [7:0] ADDR_PERIOD  = 8'h08;
  localparam logic [7:0] ADDR_HIGH    = 8'h0C;
  localparam logic [7:0] ADDR_TIMEOUT = 8'h10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_HI,
    ST_LO
  } state_t;

  state_t state_reg, state_next;

  logic [2:0]       sync_reg;
  logic             rise, fall, level;

  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic [CNT_W-1:0] hold_reg, hold_next;
  logic [CNT_W-1:0] period_reg, high_reg;
  logic [31:0]      cnt_ext;
  logic             tmo_reached;
  logic             capture, timeout_hit;

  logic             en_reg, ie_rd;
  logic             valid_reg, ovr_reg, stuck_reg;
  logic [31:0]      timeout_reg;

  logic             wr_ctrl, wr_status, wr_timeout;
  logic             clr_valid, clr_ovr, clr_stuck;
  logic             unused_addr;

  assign unused_addr = ^bus.addr_i[31:8];

  assign wr_ctrl    = bus.we_i && (bus.addr_i[7:0] == ADDR_CTRL);
  assign wr_status  = bus.we_i && (bus.addr_i[7:0] == ADDR_STATUS);
  assign wr_timeout = bus.we_i && (bus.addr_i[7:0] == ADDR_TIMEOUT);

  assign clr_valid  = wr_status & bus.data_i[0];
  assign clr_ovr    = wr_status & bus.data_i[1];
  assign clr_stuck  = wr_status & bus.data_i[2];

  // Two flops to settle the asynchronous pin, a third to remember the last settled level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_reg <= 3'b000;
    end else begin
      sync_reg <= {sync_reg[1:0], pwm_in_i};
    end
  end

  assign level = sync_reg[1];
  assign rise  =  sync_reg[1] & ~sync_reg[2];
  assign fall  = ~sync_reg[1] &  sync_reg[2];

  assign cnt_inc     = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
  assign cnt_ext     = 32'(cnt_reg);
  assign tmo_reached = (timeout_reg != 32'd0) && (cnt_ext >= timeout_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      hold_reg  <= hold_next;
    end
  end

  // EN is the registered value, so a capture in the same cycle as an EN=0 write still lands.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    hold_next   = hold_reg;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    if (!en_reg) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          state_next = ST_ARM;
          cnt_next   = '0;
        end
        ST_ARM: begin
          cnt_next = '0;
          if (rise) begin
            cnt_next   = CNT_W'(1);
            state_next = ST_HI;
          end
        end
        ST_HI: begin
          if (tmo_reached) begin
            timeout_hit = 1'b1;
            cnt_next    = '0;
            state_next  = ST_ARM;
          end else begin
            cnt_next = cnt_inc;
            if (fall) begin
              hold_next  = cnt_reg;
              state_next = ST_LO;
            end
          end
        end
        ST_LO: begin
          if (tmo_reached) begin
            timeout_hit = 1'b1;
            cnt_next    = '0;
            state_next  = ST_ARM;
          end else if (rise) begin
            capture    = 1'b1;
            cnt_next   = CNT_W'(1);
            state_next = ST_HI;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      period_reg <= '0;
      high_reg   <= '0;
    end else if (capture) begin
      period_reg <= cnt_reg;
      high_reg   <= hold_reg;
    end
  end

  // Status sets take priority over W1C clears; OVR looks at VALID before this cycle's write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg <= 1'b0;
      ovr_reg   <= 1'b0;
      stuck_reg <= 1'b0;
    end else begin
      valid_reg <= capture | (valid_reg & ~clr_valid);
      ovr_reg   <= (capture & valid_reg) | (ovr_reg & ~clr_ovr);
      stuck_reg <= timeout_hit | (stuck_reg & ~clr_stuck);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      en_reg      <= 1'b0;
      timeout_reg <= TIMEOUT_DEF;
    end else begin
      if (wr_ctrl) begin
        en_reg <= bus.data_i[0];
      end
      if (wr_timeout) begin
        timeout_reg <= bus.data_i;
      end
    end
  end

`ifdef PWM_CAPTURE_IRQ_EN
  logic ie_reg;
  logic irq_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ie_reg  <= 1'b0;
      irq_reg <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ie_reg <= bus.data_i[1];
      end
      irq_reg <= ie_reg & (valid_reg | stuck_reg);
    end
  end

  assign ie_rd = ie_reg;
  assign irq_o = irq_reg;
`else
  assign ie_rd = 1'b0;
  assign irq_o = 1'b0;
`endif

  always_comb begin
    bus.data_o = 32'd0;
    case (bus.addr_i[7:0])
      ADDR_CTRL:    bus.data_o = {30'd0, ie_rd, en_reg};
      ADDR_STATUS:  bus.data_o = {28'd0, level, stuck_reg, ovr_reg, valid_reg};
      ADDR_PERIOD:  bus.data_o = 32'(period_reg);
      ADDR_HIGH:    bus.data_o = 32'(high_reg);
      ADDR_TIMEOUT: bus.data_o = timeout_reg;
      default:      bus.data_o = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Randomized bench for pwm_capture: a timestamp-based model predicts every register and irq_o.
// Small counter width so saturation is reachable in a short run.
module tb_pwm_capture;
  localparam int          CNT_W = 8;
  localparam longint      MAXC  = 255;
  localparam logic [31:0] TDEF  = 32'd1_000_000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pin = 1'b0;
  logic irq;

  pwm_capture_if bus ();

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT_DEF(TDEF)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .pwm_in_i (pin),
    .irq_o    (irq)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
  endtask

  // Model: time stamps of detected edges; the block sees the pin two samples late.
  int          mode = 0;          // 0 idle, 1 armed, 2 high phase, 3 low phase
  longint      k = 0, r_t = 0, hold_c = 0;
  logic [31:0] m_per = 0, m_high = 0, m_tmo = TDEF;
  bit          a1 = 0, a2 = 0, a3 = 0;
  bit          m_en = 0, m_ie = 0, m_valid = 0, m_ovr = 0, m_stuck = 0, m_irq = 0;
  bit          cap_pending = 0, ready = 0;

  function automatic longint elapsed(input longint at);
    longint e;
    e = at - r_t;
    return (e > MAXC) ? MAXC : e;
  endfunction

  always @(posedge clk) begin : model
    bit rise, fall, cap, to;
    bit w;
    logic [7:0] a;
    logic [31:0] d;
    longint c;
    k = k + 1;
    if (!rst) begin
      mode = 0; m_per = 0; m_high = 0; m_tmo = TDEF; hold_c = 0;
      m_en = 0; m_ie = 0; m_valid = 0; m_ovr = 0; m_stuck = 0; m_irq = 0;
      a1 = 0; a2 = 0; a3 = 0;
      ready = 1;
    end else begin
      rise = a2 & ~a3;
      fall = ~a2 & a3;
      cap = 0;
      to = 0;
      c = elapsed(k);
      if (!m_en) mode = 0;
      else if (mode == 0) mode = 1;
      else if (mode == 1) begin
        if (rise) begin mode = 2; r_t = k; end
      end else if (m_tmo != 0 && c >= m_tmo) begin
        to = 1; mode = 1;
      end else if (mode == 2 && fall) begin
        hold_c = c; mode = 3;
      end else if (mode == 3 && rise) begin
        cap = 1; m_per = 32'(c); m_high = 32'(hold_c); r_t = k; mode = 2;
      end
`ifdef PWM_CAPTURE_IRQ_EN
      m_irq = m_ie & (m_valid | m_stuck);
`else
      m_irq = 0;
`endif
      w = bus.we_i;
      a = bus.addr_i[7:0];
      d = bus.data_i;
      m_ovr   = (cap & m_valid) | (m_ovr & ~(w && a == 8'h04 && d[1]));
      m_valid = cap | (m_valid & ~(w && a == 8'h04 && d[0]));
      m_stuck = to | (m_stuck & ~(w && a == 8'h04 && d[2]));
      if (w && a == 8'h00) begin
        m_en = d[0];
`ifdef PWM_CAPTURE_IRQ_EN
        m_ie = d[1];
`endif
      end
      if (w && a == 8'h10) m_tmo = d;
      a3 = a2; a2 = a1; a1 = pin;
    end
    cap_pending = m_en && mode == 3 && a2 && !a3 &&
                  !(m_tmo != 0 && elapsed(k + 1) >= m_tmo);
  end

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (addr[7:0])
      8'h00:   return {30'd0, m_ie, m_en};
      8'h04:   return {28'd0, a2, m_stuck, m_ovr, m_valid};
      8'h08:   return m_per;
      8'h0C:   return m_high;
      8'h10:   return m_tmo;
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (ready) begin
      check("irq_cycle", {31'd0, irq}, {31'd0, m_irq});
      check("rd_cycle", bus.data_o, model_read(bus.addr_i));
    end
  end

  // Pin driver: 0 low, 1 high, 2 fixed hi/lo wave, 3 random wave.
  int pin_mode = 0;
  int hi_len = 3, lo_len = 5;

  initial begin
    int left;
    left = 1;
    forever begin
      @(posedge clk);
      #1;
      case (pin_mode)
        0: pin = 1'b0;
        1: pin = 1'b1;
        default: begin
          if (left <= 1) begin
            pin = ~pin;
            if (pin_mode == 3) begin
              hi_len = $urandom_range(1, 40);
              lo_len = $urandom_range(1, 40);
            end
            left = pin ? hi_len : lo_len;
          end else begin
            left--;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    $display("WR t=%0t addr=0x%02h data=0x%08h", $time, a[7:0], d);
    bus.we_i   = 1'b1;
    bus.addr_i = a;
    bus.data_i = d;
    tick();
    bus.we_i   = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    bus.addr_i = a;
    @(negedge clk);
    v = bus.data_o;
    $display("RD t=%0t addr=0x%02h data=0x%08h", $time, a[7:0], v);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    logic [31:0] v;
    bit got;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      rd(32'h04, v);
      got = v[0];
    end
    check(name, {31'd0, got}, 32'd1);
  endtask

  task automatic wait_pending(input string name);
    bit got;
    got = cap_pending;
    for (int i = 0; i < 100 && !got; i++) begin
      tick();
      got = cap_pending;
    end
    check(name, {31'd0, got}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d", n_pass, n_chk);
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int sel;
    bus.we_i = 1'b0;
    bus.addr_i = 32'd0;
    bus.data_i = 32'd0;
    rst = 1'b0;
    idle(2);
    rst = 1'b1;

    rd(32'h00, v); check("rst_ctrl", v, 32'd0);
    rd(32'h04, v); check("rst_status", v, 32'd0);
    rd(32'h08, v); check("rst_period", v, 32'd0);
    rd(32'h0C, v); check("rst_high", v, 32'd0);
    rd(32'h10, v); check("rst_timeout", v, TDEF);

    // Steady 3 high / 5 low.
    hi_len = 3; lo_len = 5;
    wr(32'h00, 32'd1);
    pin_mode = 2;
    idle(30);
    pin_mode = 0;
    idle(20);
    rd(32'h08, v); check("steady_period", v, 32'd8);
    rd(32'h0C, v); check("steady_high", v, 32'd3);
    rd(32'h04, v); check("steady_valid", v & 32'd1, 32'd1);
    wr(32'h04, 32'd1);
    rd(32'h04, v); check("w1c_valid", v & 32'd1, 32'd0);
    pin_mode = 2;
    idle(20);
    pin_mode = 0;
    idle(12);
    rd(32'h04, v); check("valid_again", v & 32'd1, 32'd1);

    // Overflow over several uncleared periods.
    wr(32'h04, 32'd7);
    pin_mode = 2;
    idle(40);
    pin_mode = 0;
    idle(20);
    rd(32'h04, v); check("ovr_status", v, 32'd3);
    rd(32'h08, v); check("ovr_period", v, 32'd8);
    rd(32'h0C, v); check("ovr_high", v, 32'd3);
    wr(32'h04, 32'd7);
    rd(32'h04, v); check("ovr_cleared", v, 32'd0);

    // Stuck-high input.
    wr(32'h10, 32'd100);
    wr(32'h00, 32'd0);
    wr(32'h00, 32'd1);
    idle(3);
    pin_mode = 1;
    idle(130);
    rd(32'h04, v); check("stuck_status", v, 32'hC);
    rd(32'h08, v); check("stuck_period", v, 32'd8);
    wr(32'h04, 32'd7);
    rd(32'h04, v); check("stuck_cleared", v, 32'h8);
    wr(32'h10, 32'd0);

    // Interrupt.
    wr(32'h00, 32'd3);
`ifdef PWM_CAPTURE_IRQ_EN
    rd(32'h00, v); check("ctrl_ie", v, 32'd3);
`else
    rd(32'h00, v); check("ctrl_no_ie", v, 32'd1);
`endif
    pin_mode = 2;
    idle(30);
    pin_mode = 0;
    idle(10);
`ifdef PWM_CAPTURE_IRQ_EN
    check("irq_on", {31'd0, irq}, 32'd1);
`else
    check("irq_tied", {31'd0, irq}, 32'd0);
`endif
    wr(32'h04, 32'd7);
    idle(2);
    check("irq_off", {31'd0, irq}, 32'd0);

    // Disable mid high phase, then re-enable on a 10/10 wave.
    wr(32'h00, 32'd0);
    wr(32'h00, 32'd1);
    idle(3);
    pin_mode = 1;
    idle(6);
    wr(32'h00, 32'd0);
    idle(4);
    pin_mode = 0;
    idle(4);
    rd(32'h04, v); check("dis_status", v, 32'd0);
    rd(32'h08, v); check("dis_period", v, 32'd8);
    hi_len = 10; lo_len = 10;
    pin_mode = 2;
    idle($urandom_range(0, 19));
    wr(32'h00, 32'd1);
    wait_valid("reen_valid_wait");
    rd(32'h08, v); check("reen_period", v, 32'd20);
    rd(32'h0C, v); check("reen_high", v, 32'd10);

    // Capture coincident with W1C of VALID (VALID already set).
    wait_pending("w1c_pend_wait");
    wr(32'h04, 32'd1);
    rd(32'h04, v); check("cap_vs_w1c", v & 32'd3, 32'd3);

    // Capture coincident with EN=0.
    wr(32'h04, 32'd7);
    wait_pending("dis_pend_wait");
    wr(32'h00, 32'd0);
    rd(32'h04, v); check("cap_vs_dis", v & 32'd1, 32'd1);
    rd(32'h08, v); check("cap_vs_dis_per", v, 32'd20);

    // Saturation with timeout disabled.
    pin_mode = 0;
    idle(25);
    wr(32'h04, 32'd7);
    wr(32'h00, 32'd1);
    idle(3);
    pin_mode = 1;
    idle(300);
    pin_mode = 0;
    idle(300);
    pin_mode = 1;
    idle(10);
    rd(32'h08, v); check("sat_period", v, 32'd255);
    rd(32'h0C, v); check("sat_high", v, 32'd255);

    // Randomized traffic against the model.
    pin_mode = 3;
    for (int i = 0; i < 2500; i++) begin
      if (i == 1200) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        rd(32'h10, v); check("mid_rst_timeout", v, TDEF);
        rd(32'h08, v); check("mid_rst_period", v, 32'd0);
        wr(32'h00, 32'd1);
      end
      sel = $urandom_range(0, 99);
      if (sel < 5) wr(32'h04, 32'($urandom_range(0, 7)));
      else if (sel < 7) wr(32'h00, 32'($urandom_range(0, 3)) | (($urandom_range(0, 3) != 0) ? 32'd1 : 32'd0));
      else if (sel < 8) wr(32'h10, ($urandom_range(0, 1) != 0) ? 32'($urandom_range(10, 60)) : 32'd0);
      else if (sel < 9) wr(32'($urandom_range(8'h14, 8'hFF)), $urandom);
      else begin
        case ($urandom_range(0, 6))
          0: bus.addr_i = 32'h00;
          1: bus.addr_i = 32'h04;
          2: bus.addr_i = 32'h08;
          3: bus.addr_i = 32'h0C;
          4: bus.addr_i = 32'h10;
          5: bus.addr_i = 32'h18;
          default: bus.addr_i = 32'h0000_0104;
        endcase
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Memory-mapped PWM input-capture peripheral on the SoC bus, a slave beside the PWM generator.
- Measures the period and high time of an external PWM waveform and exposes them to the core.
- Its main use is loopback and closed-loop checks of the PWM outputs. It is the receive-side counterpart of the PWM generator.

Parameters:
- CNT_W, 32: width of the cycle counter and of the PERIOD/HIGH result registers (8..32).
- TIMEOUT_DEF, 32'd1_000_000: reset value of the TIMEOUT register, in clk cycles.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-low.
- we_i  in  1  bus write strobe.
- addr_i  in  32  bus address; only addr_i[7:0] is decoded.
- data_i  in  32  bus write data.
- data_o  out  32  bus read data; combinational from addr_i.
- pwm_in_i  in  1  asynchronous PWM input.
- irq_o  out  1  level interrupt.

Behaviour:
- Register map (byte offsets):
  - 0x00 CTRL: bit0 EN, bit1 IE. Read/write.
  - 0x04 STATUS: bit0 VALID, bit1 OVR, bit2 STUCK, bit3 LEVEL (read-only). Writing 1 to bits 0..2 clears them.
  - 0x08 PERIOD: read-only.
  - 0x0C HIGH: read-only.
  - 0x10 TIMEOUT: read/write.
  - Unmapped offsets read 0; writes to them are ignored.
- Reset values (rst=0 at a clk edge):
  - CTRL=0, STATUS=0, PERIOD=0, HIGH=0, TIMEOUT=TIMEOUT_DEF.
  - Counter=0, state=IDLE, irq_o=0.
- Input path:
  - pwm_in_i passes through a 2-flop synchronizer, then a third flop for edge detection.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Edge detect latency is 3 clk from a pin transition.
  - LEVEL always reflects s2.
- FSM:
  - IDLE: counter held at 0. Next state is ARM when EN=1.
  - ARM: wait for rise. On rise, counter<=1 and go to HI.
  - HI: counter+1 each cycle. On fall, hold_hi<=counter, counter<=counter+1, go to LO.
  - LO: counter+1 each cycle. On rise:
    - PERIOD<=counter and HIGH<=hold_hi.
    - VALID<=1; if VALID was already 1, also set OVR<=1.
    - counter<=1 and go to HI.
- Counting convention: PERIOD is the number of clk cycles between consecutive detected rising edges; HIGH is the number of cycles from a rise to the following fall.
- Timeout:
  - Applies in HI or LO when counter >= TIMEOUT.
  - STUCK<=1 and next state is ARM.
  - PERIOD and HIGH are not updated.
  - TIMEOUT=0 disables the timeout.
- Counter saturation: the counter saturates at all-ones and never wraps. With the timeout disabled, a saturated count is reported as-is.
- EN cleared in any state:
  - Go to IDLE on the next clk.
  - Results and STATUS are retained and the partial measurement is discarded.
  - Re-enabling restarts at ARM; the first captured period is always a full period.
- Simultaneous events:
  - Capture and a W1C of VALID in the same cycle: the capture wins, VALID=1. OVR is evaluated from VALID before the write.
  - Bus write to CTRL.EN=0 in the same cycle as a capture: the capture completes, then the FSM goes to IDLE.
- Reads have no side effects.
- irq_o = IE & (VALID | STUCK), registered, so it lags the status change by 1 clk.
- Synchronous reset mid-measurement returns the block fully to its reset state on that edge.

Optional Feature:
- Macro: PWM_CAPTURE_IRQ_EN.
- Defined: irq_o and CTRL.IE behave as specified above.
- Not defined:
  - irq_o is tied to 0 and CTRL.IE is not implemented (reads 0, writes ignored).
  - All other behaviour is unchanged.

Test Plan:
- Reset and register defaults: hold rst=0 for 2 clk, then read each register -> CTRL=0, STATUS=0, PERIOD=0, HIGH=0, TIMEOUT=TIMEOUT_DEF.
- Steady waveform: EN=1, drive 3 cycles high / 5 low, repeated -> after the second rise, PERIOD=8, HIGH=3, VALID=1. Writing 0x1 to STATUS -> VALID=0; the next period sets it again.
- Overflow: leave VALID uncleared over 3 periods -> OVR=1, PERIOD/HIGH hold the latest period. Writing 0x7 clears both bits.
- Stuck input: TIMEOUT=100, pin held high after one rise -> STUCK=1 and LEVEL=1 about 100 clk later, PERIOD unchanged.
- IRQ: IE=1, one valid capture -> irq_o=1 one clk after VALID. W1C VALID -> irq_o=0 one clk later. Without the macro, irq_o=0 throughout.
- Disable/re-enable and edge cases:
  - Clear EN mid-HI -> FSM in IDLE.
  - Re-enable with a 10/10 waveform -> first PERIOD=20, HIGH=10, no partial value.
  - Capture coincident with W1C -> VALID=1.
